// File: rtl/axis_packet_gen_pkg.sv
// Shared encodings for the AXI-Stream packet generator: pattern modes, FSM
// states and Galois LFSR tap masks per data width.
package axis_packet_gen_pkg;

    typedef enum logic [1:0] {
        MODE_INC     = 2'b00,
        MODE_CONST   = 2'b01,
        MODE_LFSR    = 2'b10,
        MODE_INC_ALT = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SEND = 2'b01,
        ST_GAP  = 2'b10,
        ST_FIN  = 2'b11
    } state_e;

    // Right-shifting Galois masks; bit k set means polynomial term x^(k+1).
    localparam logic [63:0] LFSR_TAPS_8  = 64'h0000_0000_0000_00B8;
    localparam logic [63:0] LFSR_TAPS_16 = 64'h0000_0000_0000_B400;
    localparam logic [63:0] LFSR_TAPS_32 = 64'h0000_0000_8020_0003;
    localparam logic [63:0] LFSR_TAPS_64 = 64'hD800_0000_0000_0000;

    function automatic logic [63:0] lfsr_taps(input int width);
        case (width)
            8:       return LFSR_TAPS_8;
            16:      return LFSR_TAPS_16;
            32:      return LFSR_TAPS_32;
            64:      return LFSR_TAPS_64;
            default: return 64'd1 << (width - 1);
        endcase
    endfunction

endpackage

// File: rtl/axis_packet_gen_if.sv
// AXI-Stream bus between the packet generator (master) and its sink (slave).
interface axis_packet_gen_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic                    tvalid;
    logic                    tready;
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tstrb;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tlast;

    modport master (output tvalid, tdata, tstrb, tkeep, tlast, input tready);
    modport slave  (input tvalid, tdata, tstrb, tkeep, tlast, output tready);
endinterface

// File: rtl/axis_pkt_pattern.sv
// Data-pattern generator: first beat of a packet and the successor of the
// current beat for increment, constant and Galois LFSR modes.
module axis_pkt_pattern
    import axis_packet_gen_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  mode_e                 i_mode,
    input  logic [DATA_WIDTH-1:0] i_seed,
    input  logic [DATA_WIDTH-1:0] i_cur,
    output logic [DATA_WIDTH-1:0] o_first,
    output logic [DATA_WIDTH-1:0] o_next
);
    localparam logic [63:0]           TAPS_FULL = lfsr_taps(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] TAPS      = TAPS_FULL[DATA_WIDTH-1:0];

    logic [DATA_WIDTH-1:0] w_first;

    // An all-zero LFSR state would lock up, so seed 0 is promoted to 1.
    always_comb begin
        w_first = i_seed;
        if (i_mode == MODE_LFSR && i_seed == '0)
            w_first = DATA_WIDTH'(1);
    end

    always_comb begin
        case (i_mode)
            MODE_CONST: o_next = w_first;
            MODE_LFSR:  o_next = {1'b0, i_cur[DATA_WIDTH-1:1]} ^ (i_cur[0] ? TAPS : '0);
            default:    o_next = i_cur + DATA_WIDTH'(1);
        endcase
    end

    assign o_first = w_first;

endmodule

// File: rtl/axis_packet_gen.sv
// AXI-Stream packet generator: runs of fixed-length packets with a
// configurable pattern, inter-packet gap, packet count and abort.
module axis_packet_gen
    import axis_packet_gen_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8,
    parameter int CNT_WIDTH  = 16,
    parameter int GAP_WIDTH  = 8
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  start,
    input  logic                  abort,
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] seed,
    input  logic [LEN_WIDTH-1:0]  pkt_len,
    input  logic [CNT_WIDTH-1:0]  pkt_count,
    input  logic [GAP_WIDTH-1:0]  gap,
    axis_packet_gen_if.master     m_axis,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  pkts_sent
);
    state_e                r_state;
    mode_e                 r_mode;
    logic [DATA_WIDTH-1:0] r_seed;
    logic [LEN_WIDTH-1:0]  r_len_m1;
    logic [CNT_WIDTH-1:0]  r_count;
    logic [GAP_WIDTH-1:0]  r_gap;
    logic [LEN_WIDTH-1:0]  r_beat;
    logic [GAP_WIDTH-1:0]  r_gap_cnt;
    logic                  r_abort_pend;
    logic [DATA_WIDTH-1:0] r_tdata;
    logic                  r_tvalid;
    logic                  r_tlast;
    logic                  r_busy;
    logic                  r_done;
    logic [CNT_WIDTH-1:0]  r_pkts;

    logic                  w_idle;
    mode_e                 w_mode;
    logic [DATA_WIDTH-1:0] w_seed;
    logic [DATA_WIDTH-1:0] w_first;
    logic [DATA_WIDTH-1:0] w_next;
    logic [LEN_WIDTH-1:0]  w_len_m1_in;
    logic [LEN_WIDTH-1:0]  w_beat_inc;
    logic [CNT_WIDTH-1:0]  w_pkts_inc;
    logic                  w_acc;
    logic                  w_count_hit;

    // In IDLE the pattern unit sees the live config so beat 0 is ready at start.
    assign w_idle      = (r_state == ST_IDLE);
    assign w_mode      = w_idle ? mode_e'(mode) : r_mode;
    assign w_seed      = w_idle ? seed : r_seed;
    assign w_len_m1_in = (pkt_len == '0) ? '0 : pkt_len - LEN_WIDTH'(1);
    assign w_beat_inc  = r_beat + LEN_WIDTH'(1);
    assign w_pkts_inc  = r_pkts + CNT_WIDTH'(1);
    assign w_acc       = r_tvalid & m_axis.tready;
    assign w_count_hit = (r_count != '0) && (w_pkts_inc == r_count);

    axis_pkt_pattern #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_pattern (
        .i_mode  (w_mode),
        .i_seed  (w_seed),
        .i_cur   (r_tdata),
        .o_first (w_first),
        .o_next  (w_next)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state      <= ST_IDLE;
            r_mode       <= MODE_INC;
            r_seed       <= '0;
            r_len_m1     <= '0;
            r_count      <= '0;
            r_gap        <= '0;
            r_beat       <= '0;
            r_gap_cnt    <= '0;
            r_abort_pend <= 1'b0;
            r_tdata      <= '0;
            r_tvalid     <= 1'b0;
            r_tlast      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pkts       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mode       <= mode_e'(mode);
                        r_seed       <= seed;
                        r_len_m1     <= w_len_m1_in;
                        r_count      <= pkt_count;
                        r_gap        <= gap;
                        r_pkts       <= '0;
                        r_abort_pend <= 1'b0;
                        r_beat       <= '0;
                        r_tdata      <= w_first;
                        r_tlast      <= (w_len_m1_in == '0);
                        r_tvalid     <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (abort)
                        r_abort_pend <= 1'b1;
                    if (w_acc && r_tlast) begin
                        r_pkts <= w_pkts_inc;
                        // Count completion and abort share the FIN exit.
                        if (w_count_hit || r_abort_pend || abort) begin
                            r_tvalid <= 1'b0;
                            r_tlast  <= 1'b0;
                            r_done   <= 1'b1;
                            r_state  <= ST_FIN;
                        end else if (r_gap != '0) begin
                            r_tvalid  <= 1'b0;
                            r_tlast   <= 1'b0;
                            r_gap_cnt <= r_gap;
                            r_state   <= ST_GAP;
                        end else begin
                            r_beat  <= '0;
                            r_tdata <= w_first;
                            r_tlast <= (r_len_m1 == '0);
                        end
                    end else if (w_acc) begin
                        r_beat  <= w_beat_inc;
                        r_tdata <= w_next;
                        r_tlast <= (w_beat_inc == r_len_m1);
                    end
                end
                ST_GAP: begin
                    if (abort) begin
                        r_done  <= 1'b1;
                        r_state <= ST_FIN;
                    end else if (r_gap_cnt == GAP_WIDTH'(1)) begin
                        r_beat   <= '0;
                        r_tdata  <= w_first;
                        r_tlast  <= (r_len_m1 == '0);
                        r_tvalid <= 1'b1;
                        r_state  <= ST_SEND;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - GAP_WIDTH'(1);
                    end
                end
                ST_FIN: begin
                    r_done       <= 1'b0;
                    r_busy       <= 1'b0;
                    r_abort_pend <= 1'b0;
                    r_state      <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign m_axis.tvalid = r_tvalid;
    assign m_axis.tdata  = r_tdata;
    assign m_axis.tlast  = r_tlast;
    assign m_axis.tstrb  = '1;
    assign m_axis.tkeep  = '1;
    assign busy          = r_busy;
    assign done          = r_done;
    assign pkts_sent     = r_pkts;

endmodule

// File: tb/tb_axis_packet_gen.sv
// Scoreboard bench for axis_packet_gen: a behavioural model queues expected
// beats per run, a negedge monitor pops and compares accepted beats.
module tb_axis_packet_gen;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } beat_t;

    logic        aclk;
    logic        aresetn;
    logic        start;
    logic        abort;
    logic [1:0]  mode;
    logic [7:0]  seed;
    logic [7:0]  pkt_len;
    logic [15:0] pkt_count;
    logic [7:0]  gap;
    logic        busy;
    logic        done;
    logic [15:0] pkts_sent;

    axis_packet_gen_if #(.DATA_WIDTH(8)) axis_if ();

    axis_packet_gen #(
        .DATA_WIDTH (8),
        .LEN_WIDTH  (8),
        .CNT_WIDTH  (16),
        .GAP_WIDTH  (8)
    ) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .start     (start),
        .abort     (abort),
        .mode      (mode),
        .seed      (seed),
        .pkt_len   (pkt_len),
        .pkt_count (pkt_count),
        .gap       (gap),
        .m_axis    (axis_if),
        .busy      (busy),
        .done      (done),
        .pkts_sent (pkts_sent)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int    checks = 0;
    int    errors = 0;
    beat_t exp_q[$];
    int    exp_gap = 0;
    int    ready_mode = 0;
    bit    mon_en = 1;
    bit    after_last = 0;
    int    idle = 0;
    int    cyc = 0;
    int    last_cyc = -100;
    int    done_cnt = 0;
    int    beats_acc = 0;
    bit    stall_q = 0;
    logic [7:0] hold_d;
    logic       hold_l;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference pattern computed from the rules: +1 mod 256, constant, or
    // Galois LFSR step for x^8+x^6+x^5+x^4+1.
    function automatic logic [7:0] ref_next(input logic [1:0] md, input logic [7:0] first,
                                            input logic [7:0] cur);
        logic [7:0] s;
        case (md)
            2'b01: return first;
            2'b10: begin
                s = cur >> 1;
                if (cur[0]) s = s ^ 8'hB8;
                return s;
            end
            default: return cur + 8'd1;
        endcase
    endfunction

    task automatic push_run(input logic [1:0] md, input logic [7:0] sd,
                            input logic [7:0] ln, input int npkts);
        int         len;
        logic [7:0] first;
        logic [7:0] v;
        beat_t      b;
        len   = (ln == 0) ? 1 : int'(ln);
        first = (md == 2'b10 && sd == 8'd0) ? 8'd1 : sd;
        for (int p = 0; p < npkts; p++) begin
            v = first;
            for (int i = 0; i < len; i++) begin
                b.d = v;
                b.l = (i == len - 1);
                exp_q.push_back(b);
                v = ref_next(md, first, v);
            end
        end
    endtask

    initial begin
        axis_if.tready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            case (ready_mode)
                0:       axis_if.tready = 1'b1;
                1:       axis_if.tready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: axis_if.tready = ($urandom_range(0, 1) == 1);
            endcase
        end
    end

    always @(negedge aclk) begin
        beat_t e;
        cyc++;
        if (aresetn && mon_en) begin
            if (stall_q) begin
                chk("stall_tvalid", axis_if.tvalid, 1);
                chk("stall_tdata", axis_if.tdata, hold_d);
                chk("stall_tlast", axis_if.tlast, hold_l);
            end
            stall_q = 0;
            if (after_last) begin
                if (axis_if.tvalid) begin
                    chk("gap_cycles", idle, exp_gap);
                    after_last = 0;
                end else begin
                    idle++;
                end
            end
            if (axis_if.tvalid) begin
                if (axis_if.tready) begin
                    chk("beat_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("tdata", axis_if.tdata, e.d);
                        chk("tlast", axis_if.tlast, e.l);
                    end
                    chk("tstrb_tkeep", {axis_if.tstrb, axis_if.tkeep}, 2'b11);
                    beats_acc++;
                    if (axis_if.tlast) begin
                        after_last = 1;
                        idle       = 0;
                        last_cyc   = cyc;
                    end
                end else begin
                    stall_q = 1;
                    hold_d  = axis_if.tdata;
                    hold_l  = axis_if.tlast;
                end
            end
            if (done) begin
                done_cnt++;
                chk("done_after_tlast", cyc - last_cyc, 1);
            end
        end
    end

    task automatic do_run(input logic [1:0] md, input logic [7:0] sd, input logic [7:0] ln,
                          input logic [15:0] cnt, input logic [7:0] gp, input int rdy,
                          input int abort_at, input int exp_pkts, input bit poke_start);
        int  d0;
        bit  seen;
        push_run(md, sd, ln, exp_pkts);
        exp_gap    = int'(gp);
        ready_mode = rdy;
        @(posedge aclk);
        #1;
        after_last = 0;
        beats_acc  = 0;
        d0         = done_cnt;
        mode = md; seed = sd; pkt_len = ln; pkt_count = cnt; gap = gp;
        start = 1'b1;
        @(posedge aclk);
        #1;
        start     = 1'b0;
        mode      = 2'($urandom_range(0, 3));
        seed      = 8'($urandom);
        pkt_len   = 8'($urandom);
        pkt_count = 16'($urandom);
        gap       = 8'($urandom);
        seen      = 0;
        for (int c = 0; c < 3000 && !seen; c++) begin
            @(posedge aclk);
            #1;
            start = 1'b0;
            abort = 1'b0;
            if (abort_at >= 0 && beats_acc == abort_at)
                abort = 1'b1;
            if (poke_start && c == 2 && busy && !done) begin
                start = 1'b1;
                seed  = 8'($urandom);
            end
            seen = (done_cnt > d0);
        end
        abort = 1'b0;
        start = 1'b0;
        chk("run_completed", seen, 1);
        repeat (3) @(posedge aclk);
        #1;
        chk("done_pulses", done_cnt - d0, 1);
        chk("pkts_sent", pkts_sent, exp_pkts);
        chk("busy_after_run", busy, 0);
        chk("tvalid_after_run", axis_if.tvalid, 0);
        chk("expected_left", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        logic [1:0]  rm;
        logic [7:0]  rs;
        logic [7:0]  rl;
        logic [15:0] rc;
        logic [7:0]  rg;
        aresetn = 1'b0;
        start = 1'b0; abort = 1'b0; mode = 2'b00; seed = 8'd0;
        pkt_len = 8'd0; pkt_count = 16'd0; gap = 8'd0;
        #23;
        chk("rst_tvalid", axis_if.tvalid, 0);
        chk("rst_tlast", axis_if.tlast, 0);
        chk("rst_tdata", axis_if.tdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pkts_sent", pkts_sent, 0);
        @(negedge aclk);
        aresetn = 1'b1;

        do_run(2'b00, 8'd2, 8'd5, 16'd1, 8'd0, 0, -1, 1, 0);
        do_run(2'b00, 8'd2, 8'd5, 16'd1, 8'd0, 1, -1, 1, 0);
        do_run(2'b00, 8'hFE, 8'd3, 16'd3, 8'd2, 0, -1, 3, 0);
        do_run(2'b10, 8'd0, 8'd8, 16'd1, 8'd0, 2, -1, 1, 0);
        do_run(2'b00, 8'h40, 8'd4, 16'd0, 8'd0, 0, 5, 2, 0);

        for (int r = 0; r < 10; r++) begin
            rm = 2'($urandom_range(0, 3));
            rs = 8'($urandom);
            rl = 8'($urandom_range(0, 6));
            rc = 16'($urandom_range(1, 3));
            rg = 8'($urandom_range(0, 3));
            do_run(rm, rs, rl, rc, rg, (r % 2 == 0) ? 2 : 1, -1, int'(rc), 1);
        end

        // Reset in the middle of a long packet.
        mon_en     = 0;
        ready_mode = 0;
        @(posedge aclk);
        #1;
        mode = 2'b00; seed = 8'h10; pkt_len = 8'd20; pkt_count = 16'd1; gap = 8'd0;
        start = 1'b1;
        @(posedge aclk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge aclk);
        #2;
        aresetn = 1'b0;
        #1;
        chk("midrst_tvalid", axis_if.tvalid, 0);
        chk("midrst_tlast", axis_if.tlast, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_pkts_sent", pkts_sent, 0);
        repeat (2) @(negedge aclk);
        aresetn    = 1'b1;
        stall_q    = 0;
        after_last = 0;
        exp_q.delete();
        mon_en     = 1;
        do_run(2'b00, 8'h33, 8'd3, 16'd2, 8'd1, 2, -1, 2, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_packet_gen.md
AXIS_PACKET_GEN -- requirements
Module: axis_packet_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, tdata width in bits (multiple of 8, 8..64).
REQ-002 SHALL have parameter LEN_WIDTH, default 8, width of pkt_len.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, width of pkt_count and pkts_sent.
REQ-004 SHALL have parameter GAP_WIDTH, default 8, width of gap.
REQ-005 SHALL have one clock and an asynchronous, active-low reset: aclk (input, 1) is the sole clock; aresetn (input, 1) is the asynchronous active-low reset.
REQ-006 SHALL have the ports start (input, 1), a single-cycle request to begin a run, and abort (input, 1), a request to end the run at the next packet boundary.
REQ-007 SHALL have the ports mode (input, 2), the pattern select (00 increment, 01 constant, 10 LFSR, 11 treated as 00), and seed (input, DATA_WIDTH), the first data value of each packet.
REQ-008 SHALL have the port pkt_len (input, LEN_WIDTH), the number of beats per packet, with 0 treated as 1.
REQ-009 SHALL have the ports pkt_count (input, CNT_WIDTH), the packets per run with 0 meaning continuous, and gap (input, GAP_WIDTH), the idle cycles between packets.
REQ-010 SHALL have the AXI-Stream master ports m_axis_tvalid (out, 1), m_axis_tready (in, 1), m_axis_tdata (out, DATA_WIDTH), m_axis_tstrb and m_axis_tkeep (out, DATA_WIDTH/8 each) and m_axis_tlast (out, 1).
REQ-011 SHALL have the status ports busy (out, 1), done (out, 1, single-cycle pulse) and pkts_sent (out, CNT_WIDTH).

Function
REQ-012 SHALL implement the states IDLE, SEND, GAP and FIN.
REQ-013 SHALL, on start in IDLE, latch mode, seed, pkt_len, pkt_count and gap, clear pkts_sent and enter SEND on the next edge; config input changes during a run SHALL have no effect.
REQ-014 SHALL ignore start outside IDLE.
REQ-015 SHALL assert tvalid exactly while in SEND; the first beat appears one cycle after start.
REQ-016 SHALL hold tvalid, tdata and tlast stable while tvalid=1 and tready=0, and SHALL never deassert tvalid before the handshake completes.
REQ-017 SHALL drive tstrb and tkeep all-ones.
REQ-018 SHALL make beat 0 of every packet equal seed.
REQ-019 SHALL, on each accepted beat, set the next beat to previous+1 modulo 2^DATA_WIDTH in increment mode, to seed in constant mode, and to one Galois LFSR step in LFSR mode; in LFSR mode a seed of 0 SHALL be replaced by 1.
REQ-020 SHALL assert tlast on beat index pkt_len-1, and on beat 0 when pkt_len is 0 or 1.
REQ-021 SHALL, on acceptance of a tlast beat, increment pkts_sent (wrapping at 2^CNT_WIDTH) in the same edge.
REQ-022 SHALL, after the tlast beat is accepted, go to FIN if pkt_count≠0 and the updated pkts_sent equals pkt_count, or if abort is pending.
REQ-023 SHALL otherwise go to GAP when gap>0, holding tvalid=0 for exactly gap cycles before returning to SEND.
REQ-024 SHALL otherwise, when gap=0, stay in SEND with tvalid continuously high, giving back-to-back packets.
REQ-025 SHALL, on abort in SEND, register it as pending and finish the current packet including tlast.
REQ-026 SHALL, on abort in GAP, go to FIN on the next edge; abort in IDLE SHALL be ignored.
REQ-027 SHALL give priority to pkt_count completion when abort and the final tlast acceptance coincide; both lead to FIN.
REQ-028 SHALL pulse done for one cycle in FIN and then return to IDLE.
REQ-029 SHALL assert busy in every state except IDLE.
REQ-030 SHALL hold pkts_sent after the run until the next start.

Reset
REQ-031 SHALL, on aresetn low, immediately and independent of aclk, force IDLE and set tvalid=0, tlast=0, tdata=0, busy=0, done=0, pkts_sent=0 and clear any pending abort.
REQ-032 SHALL, on reset mid-packet, truncate the packet with no tlast; the first start after release SHALL begin a fresh run.
REQ-033 SHALL deassert reset synchronously to aclk outside this block.

Structure
REQ-034 SHALL place the mode encodings, state encoding and per-width LFSR tap constants (8/16/32/64) in the shared package axis_packet_gen_pkg.
REQ-035 SHALL place the data-pattern next-value logic (increment/constant/LFSR) in one sub-module, axis_pkt_pattern; axis_packet_gen SHALL hold the FSM, beat/gap/packet counters and handshake.

Verification
REQ-036 SHALL verify: DATA_WIDTH=8, mode=00, seed=2, pkt_len=5, pkt_count=1, gap=0, tready=1 -> tdata 2,3,4,5,6, tlast on 6, done one cycle later, pkts_sent=1.
REQ-037 SHALL verify: the same run with tready toggling 1,0,0,1 repeating -> identical 5-beat sequence, tdata/tlast stable during stalls, no tvalid drop.
REQ-038 SHALL verify: pkt_len=3, pkt_count=3, gap=2, seed=0xFE -> each packet FE,FF,00, exactly 2 idle cycles between packets, pkts_sent=3, one done pulse.
REQ-039 SHALL verify: pkt_count=0, gap=0, pkt_len=4, abort asserted on beat 1 of packet 2 -> packet 2 completes with tlast, then done, pkts_sent=2.
REQ-040 SHALL verify: mode=10, seed=0, pkt_len=8 -> beat 0 = 1 and the following beats match the reference LFSR model.
REQ-041 SHALL verify: aresetn low mid-packet -> tvalid=0 immediately; start after release -> beat 0 = seed, pkts_sent counts from 0.
